// File: rtl/ext_pkg.sv
// Shared op codes for the immediate-extension/shift datapath.
// Imported by the datapath and the arbiter top.
package ext_pkg;

  localparam logic [1:0] EXT_SEXT = 2'b00;
  localparam logic [1:0] EXT_ZEXT = 2'b01;
  localparam logic [1:0] EXT_LUI  = 2'b10;
  localparam logic [1:0] EXT_BTGT = 2'b11;

endpackage

// File: rtl/ext_datapath.sv
// Combinational extend/shift datapath: sign/zero extend, LUI,
// and branch target (pc4 + sext(imm)<<2).
module ext_datapath
  import ext_pkg::*;
(
  input  logic [1:0]  op,
  input  logic [15:0] imm,
  input  logic [31:0] pc4,
  output logic [31:0] result
);

  logic [31:0] sextImm;
  logic [31:0] zextImm;
  logic [31:0] shl2Imm;
  logic [31:0] btgtSum;

  assign sextImm = {{16{imm[15]}}, imm};
  assign zextImm = {16'h0000, imm};
  assign shl2Imm = {sextImm[29:0], 2'b00};
  // Wrap-around past 2^32 is intentionally silent.
  assign btgtSum = pc4 + shl2Imm;

  always_comb begin
    result = sextImm;
    case (op)
      EXT_SEXT: result = sextImm;
      EXT_ZEXT: result = zextImm;
      EXT_LUI:  result = {imm, 16'h0000};
      EXT_BTGT: result = btgtSum;
      default:  result = sextImm;
    endcase
  end

endmodule

// File: rtl/ext_unit_arbiter.sv
// Round-robin arbiter sharing one ext_datapath between the ID immediate
// path (req0) and the branch-target path (req1); one registered result.
module ext_unit_arbiter
  import ext_pkg::*;
#(
  parameter int FIRST_GRANT = 0,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [1:0]       req0_op,
  input  logic [15:0]      req0_imm,
  input  logic [31:0]      req0_pc4,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [1:0]       req1_op,
  input  logic [15:0]      req1_imm,
  input  logic [31:0]      req1_pc4,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_data,
  output logic             rsp_id,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1
);

  localparam logic FirstGnt = 1'(FIRST_GRANT);

  logic        lastGnt;
  logic        canAccept;
  logic        grant0;
  logic        grant1;
  logic        accept0;
  logic        accept1;
  logic [1:0]  selOp;
  logic [15:0] selImm;
  logic [31:0] selPc4;
  logic [31:0] dpResult;

  assign canAccept = !rsp_valid | rsp_ready;

  // Contention goes to whoever did not win last; a lone requester always wins.
  assign grant0 = req0_valid & (!req1_valid | lastGnt);
  assign grant1 = req1_valid & (!req0_valid | !lastGnt);

  assign req0_ready = canAccept & grant0;
  assign req1_ready = canAccept & grant1;

  assign accept0 = req0_valid & req0_ready;
  assign accept1 = req1_valid & req1_ready;

  assign selOp  = grant1 ? req1_op  : req0_op;
  assign selImm = grant1 ? req1_imm : req0_imm;
  assign selPc4 = grant1 ? req1_pc4 : req0_pc4;

  ext_datapath uDatapath (
    .op     (selOp),
    .imm    (selImm),
    .pc4    (selPc4),
    .result (dpResult)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= 32'h0;
      rsp_id    <= 1'b0;
      lastGnt   <= ~FirstGnt;
      gnt_cnt0  <= '0;
      gnt_cnt1  <= '0;
    end else if (accept0 | accept1) begin
      rsp_valid <= 1'b1;
      rsp_data  <= dpResult;
      rsp_id    <= accept1;
      lastGnt   <= accept1;
      if (accept0 && gnt_cnt0 != '1)
        gnt_cnt0 <= gnt_cnt0 + CNT_W'(1);
      if (accept1 && gnt_cnt1 != '1)
        gnt_cnt1 <= gnt_cnt1 + CNT_W'(1);
    end else if (rsp_valid & rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule
